// File: rtl/fft_host_pkg.sv
// Shared types and sizing for the FFT host bridge: FSM states, the 128-bit
// beat carried on both lanes, and the frame/beat-counter dimensions.
package fft_host_pkg;

    localparam int FRAME_BEATS_C = 8;
    localparam int CNT_W         = $clog2(FRAME_BEATS_C);
    localparam int DATA_W        = 64;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ARM,
        LOAD,
        RUN,
        CAPT
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d0;
    } beat_t;

endpackage

// File: rtl/fft_host_frame_buf.sv
// One-frame register file (FRAME_BEATS_C x beat_t): one synchronous write
// port, one combinational read port. Contents are deliberately not reset.
module fft_host_frame_buf
    import fft_host_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [CNT_W-1:0] waddr,
    input  beat_t            wdata,
    input  logic [CNT_W-1:0] raddr,
    output beat_t            rdata
);

    beat_t mem [FRAME_BEATS_C];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_host_bridge.sv
// Stream-to-engine bridge: buffers one input frame, runs it through the FFT
// engine, and replays the captured results on a backpressured stream.
// Optional RUN watchdog with sticky ERR: define FFT_HOST_WATCHDOG_EN.
module fft_host_bridge
    import fft_host_pkg::*;
#(
    parameter int FRAME_BEATS = FRAME_BEATS_C,
    parameter int RD_LAT      = 2,
    parameter int TO_CYCLES   = 1024
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [DATA_W-1:0] S_D0,
    input  logic [DATA_W-1:0] S_D1,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic [DATA_W-1:0] M_Q0,
    output logic [DATA_W-1:0] M_Q1,
    output logic              M_LAST,
    output logic              FFT_START,
    input  logic              FFT_DONE,
    output logic [DATA_W-1:0] FFT_D0,
    output logic [DATA_W-1:0] FFT_D1,
    input  logic [DATA_W-1:0] FFT_Q0,
    input  logic [DATA_W-1:0] FFT_Q1,
    output logic              BUSY,
    output logic              ERR
);

    localparam int OCNT_W = CNT_W + 1;
    localparam int DLY_W  = $clog2(RD_LAT + 2);

    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_BEATS - 1);
    localparam logic [DLY_W-1:0]  DLY_DONE = DLY_W'(RD_LAT);
    localparam logic [OCNT_W-1:0] FULL_CNT = OCNT_W'(FRAME_BEATS);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DLY_W-1:0]  dly, dly_nxt;
    logic [OCNT_W-1:0] out_cnt, out_cnt_nxt;

    logic              in_we, out_we;
    logic [CNT_W-1:0]  out_raddr;
    beat_t             in_rd, out_rd;

`ifdef FFT_HOST_WATCHDOG_EN
    localparam int WD_W = $clog2(TO_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYCLES - 1);

    logic [WD_W-1:0] wd, wd_nxt;
    logic            err, err_nxt;
`endif

    fft_host_frame_buf u_in_buf (
        .clk   (CLK),
        .we    (in_we),
        .waddr (cnt),
        .wdata ({S_D1, S_D0}),
        .raddr (cnt),
        .rdata (in_rd)
    );

    fft_host_frame_buf u_out_buf (
        .clk   (CLK),
        .we    (out_we),
        .waddr (cnt),
        .wdata ({FFT_Q1, FFT_Q0}),
        .raddr (out_raddr),
        .rdata (out_rd)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            cnt     <= '0;
            dly     <= '0;
            out_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dly     <= dly_nxt;
            out_cnt <= out_cnt_nxt;
        end
    end

    // cnt is shared by FILL (write index), LOAD (read index) and CAPT (capture
    // index); each phase ends on the wrap back to 0, so the next starts clean.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        dly_nxt     = dly;
        out_cnt_nxt = out_cnt;
        in_we       = 1'b0;
        out_we      = 1'b0;
        S_READY     = 1'b0;
        FFT_START   = 1'b0;
`ifdef FFT_HOST_WATCHDOG_EN
        wd_nxt      = '0;
        err_nxt     = err;
`endif
        if (M_VALID && M_READY) begin
            out_cnt_nxt = out_cnt - 1'b1;
        end

        case (state)
            IDLE: state_nxt = FILL;
            FILL: begin
                S_READY = 1'b1;
                if (S_VALID) begin
                    in_we   = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state_nxt = ARM;
                    end
                end
            end
            ARM: begin
                if (out_cnt == '0 && !M_VALID) begin
                    FFT_START = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_IDX) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (FFT_DONE) begin
                    dly_nxt   = DLY_W'(1);
                    state_nxt = CAPT;
                end
`ifdef FFT_HOST_WATCHDOG_EN
                else if (wd == WD_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = FILL;
                end else begin
                    wd_nxt = wd + 1'b1;
                end
`endif
            end
            CAPT: begin
                if (dly != DLY_DONE) begin
                    dly_nxt = dly + 1'b1;
                end else begin
                    out_we  = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        out_cnt_nxt = FULL_CNT;
                        state_nxt   = FILL;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FFT_HOST_WATCHDOG_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wd  <= '0;
            err <= 1'b0;
        end else begin
            wd  <= wd_nxt;
            err <= err_nxt;
        end
    end

    assign ERR = err;
`else
    logic unused_cfg;
    assign unused_cfg = (TO_CYCLES == 0);
    assign ERR        = 1'b0;
`endif

    // out_cnt counts down, so FULL_CNT - out_cnt walks the buffer 0..7.
    assign out_raddr = CNT_W'(FULL_CNT - out_cnt);
    assign M_VALID   = (out_cnt != '0);
    assign M_LAST    = (out_cnt == OCNT_W'(1));
    assign M_Q0      = M_VALID ? out_rd.d0 : '0;
    assign M_Q1      = M_VALID ? out_rd.d1 : '0;

    assign FFT_D0    = (state == LOAD) ? in_rd.d0 : '0;
    assign FFT_D1    = (state == LOAD) ? in_rd.d1 : '0;
    assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_fft_host_bridge.sv
// Directed bench for fft_host_bridge with a behavioural FFT engine
// (DONE 20 cycles after START, result = {d1+4096, 3*d0+1}, RD_LAT 2).
module tb_fft_host_bridge;

    localparam int RD_LAT   = 2;
    localparam int DONE_DLY = 20;

    logic        CLK, RSTn;
    logic        S_VALID, S_READY;
    logic [63:0] S_D0, S_D1;
    logic        M_VALID, M_READY, M_LAST;
    logic [63:0] M_Q0, M_Q1;
    logic        FFT_START, FFT_DONE;
    logic [63:0] FFT_D0, FFT_D1, FFT_Q0, FFT_Q1;
    logic        BUSY, ERR;

    fft_host_bridge #(.FRAME_BEATS(8), .RD_LAT(RD_LAT), .TO_CYCLES(16)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_D0(S_D0), .S_D1(S_D1),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_Q0(M_Q0), .M_Q1(M_Q1), .M_LAST(M_LAST),
        .FFT_START(FFT_START), .FFT_DONE(FFT_DONE), .FFT_D0(FFT_D0), .FFT_D1(FFT_D1),
        .FFT_Q0(FFT_Q0), .FFT_Q1(FFT_Q1), .BUSY(BUSY), .ERR(ERR)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // engine model state
    int          start_cnt = 0, start_cyc = 0, start_long = 0, lane_err = 0;
    int          done_cyc = 0, ld_k = 0, spur_srv = 0, spur_fires = 0;
    logic        ld_active = 0, done_pend = 0, q_active = 0, prev_start = 0, spur_fired = 0;
    logic [63:0] ld0 [8];
    logic [63:0] ld1 [8];
    // controls written only by the main sequence
    int          spur_req = 0;
    logic        spur_load = 0, withhold = 0;
    int          rdy_mode = 0;

    // output monitor state
    logic [63:0] oq0 [$];
    logic [63:0] oq1 [$];
    logic        ol [$];
    int          ocyc [$];
    int          stall_err = 0;
    logic        pv = 0, pr = 0, pl = 0;
    logic [63:0] pq0 = 0, pq1 = 0;

    initial CLK = 0;
    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial begin : engine
        int jj;
        FFT_DONE = 0; FFT_Q0 = 0; FFT_Q1 = 0;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                ld_active = 0; done_pend = 0; q_active = 0; prev_start = 0;
                FFT_DONE = 0; FFT_Q0 = 0; FFT_Q1 = 0;
            end else begin
                if (FFT_START) begin
                    if (prev_start) start_long++;
                    if (FFT_D0 != 0 || FFT_D1 != 0) lane_err++;
                    start_cnt++; start_cyc = cyc; ld_k = 0; ld_active = 1;
                    done_pend = !withhold; spur_fired = 0;
                end else if (ld_active) begin
                    ld0[ld_k] = FFT_D0; ld1[ld_k] = FFT_D1; ld_k++;
                    if (ld_k == 8) ld_active = 0;
                end else if (FFT_D0 != 0 || FFT_D1 != 0) begin
                    lane_err++;
                end
                prev_start = FFT_START;
                FFT_DONE = 0;
                FFT_Q0 = 64'hBAD0_0000_0000_0000 | 64'(cyc);
                FFT_Q1 = 64'hBAD1_0000_0000_0000 | 64'(cyc);
                if (done_pend && cyc == start_cyc + DONE_DLY) begin
                    FFT_DONE = 1; done_pend = 0; done_cyc = cyc; q_active = 1;
                end
                if (spur_load && !spur_fired && ld_active && ld_k == 4) begin
                    FFT_DONE = 1; spur_fired = 1; spur_fires++;
                end
                if (spur_req != spur_srv) begin
                    FFT_DONE = 1; spur_srv++; spur_fires++;
                end
                if (q_active) begin
                    jj = cyc - done_cyc - RD_LAT;
                    if (jj >= 0 && jj < 8) begin
                        FFT_Q0 = ld0[jj] * 64'd3 + 64'd1;
                        FFT_Q1 = ld1[jj] + 64'd4096;
                    end
                    if (jj >= 7) q_active = 0;
                end
            end
        end
    end

    initial begin : monitor
        M_READY = 1;
        forever begin
            @(negedge CLK);
            M_READY = (rdy_mode == 1) ? cyc[0] : 1'b1;
            if (RSTn) begin
                if (pv && !pr && (!M_VALID || M_Q0 != pq0 || M_Q1 != pq1 || M_LAST != pl))
                    stall_err++;
                if (M_VALID && M_READY) begin
                    oq0.push_back(M_Q0); oq1.push_back(M_Q1); ol.push_back(M_LAST);
                    ocyc.push_back(cyc);
                end
                pv = M_VALID; pr = M_READY; pq0 = M_Q0; pq1 = M_Q1; pl = M_LAST;
            end else begin
                pv = 0;
            end
        end
    end

    initial begin : global_timeout
        #400000;
        $display("FAIL global_timeout run did not complete");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [63:0] b0, input logic [63:0] b1, input int gap,
                              input int hold, output int hs, output int extra);
        int t = 0;
        int guard = 0;
        hs = 0; extra = 0;
        while (hs < 8 && guard < 400) begin
            step();
            S_VALID = (gap == 0) || (t % 3 == 0);
            S_D0 = b0 + 64'(hs); S_D1 = b1 + 64'(hs);
            if (S_VALID && S_READY) hs++;
            t++; guard++;
        end
        for (int i = 0; i < hold; i++) begin
            step();
            S_VALID = 1;
            if (S_READY) extra++;
        end
        step();
        S_VALID = 0; S_D0 = 0; S_D1 = 0;
    endtask

    task automatic wait_outs(input int n, output logic ok);
        int g = 0;
        while (oq0.size() < n && g < 400) begin
            step();
            g++;
        end
        ok = (oq0.size() >= n);
    endtask

    task automatic test_reset();
        RSTn = 0; S_VALID = 0; S_D0 = 0; S_D1 = 0;
        repeat (3) step();
        tests_run++;
        if ({S_READY, M_VALID, M_LAST, FFT_START, BUSY, ERR} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b want 000000", {S_READY, M_VALID, M_LAST, FFT_START, BUSY, ERR});
        end
        tests_run++;
        if ({FFT_D0, FFT_D1, M_Q0, M_Q1} !== 256'b0) begin
            tests_failed++;
            $display("FAIL reset_data got %h want 0", {FFT_D0, FFT_D1, M_Q0, M_Q1});
        end
        RSTn = 1;
        tests_run++;
        if ({S_READY, BUSY} !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_after_release got %b want 00", {S_READY, BUSY});
        end
        step();
        tests_run++;
        if ({S_READY, BUSY} !== 2'b11) begin
            tests_failed++;
            $display("FAIL fill_after_release got %b want 11", {S_READY, BUSY});
        end
    endtask

    task automatic test_single_frame();
        int hs, ex, s0, sl0, le0, base;
        logic ok;
        logic [63:0] g0, g1;
        logic gl;
        s0 = start_cnt; sl0 = start_long; le0 = lane_err; base = oq0.size();
        send_frame(64'd0, 64'd100, 0, 0, hs, ex);
        wait_outs(base + 8, ok);
        tests_run++;
        if (hs !== 8 || ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_progress got hs=%0d outs_ok=%0d want hs=8 outs_ok=1", hs, ok);
        end
        tests_run++;
        if (start_cnt - s0 !== 1 || start_long !== sl0 || lane_err !== le0) begin
            tests_failed++;
            $display("FAIL single_start got starts=%0d long=%0d lane_err=%0d want 1 0 0",
                     start_cnt - s0, start_long - sl0, lane_err - le0);
        end
        for (int j = 0; j < 8; j++) begin
            tests_run++;
            if (ld0[j] !== 64'(j) || ld1[j] !== 64'(100 + j)) begin
                tests_failed++;
                $display("FAIL single_load[%0d] got %0d/%0d want %0d/%0d", j, ld0[j], ld1[j], j, 100 + j);
            end
            g0 = (base + j < oq0.size()) ? oq0[base + j] : 64'hx;
            g1 = (base + j < oq1.size()) ? oq1[base + j] : 64'hx;
            gl = (base + j < ol.size()) ? ol[base + j] : 1'bx;
            tests_run++;
            if (g0 !== 64'(3 * j + 1) || g1 !== 64'(4196 + j) || gl !== (j == 7)) begin
                tests_failed++;
                $display("FAIL single_out[%0d] got %0d/%0d last=%b want %0d/%0d last=%b",
                         j, g0, g1, gl, 3 * j + 1, 4196 + j, (j == 7));
            end
        end
    endtask

    task automatic test_backpressure();
        int hs, hs2, ex, s0, st0, base;
        logic ok;
        logic [63:0] g0, g1, e0, e1;
        logic gl;
        rdy_mode = 1; s0 = start_cnt; st0 = stall_err; base = oq0.size();
        send_frame(64'h1000, 64'h2000, 0, 0, hs, ex);
        send_frame(64'h3000, 64'h4000, 0, 0, hs2, ex);
        tests_run++;
        if (hs2 !== 8 || start_cnt - s0 !== 1 || S_READY !== 1'b0 || M_VALID !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_arm_hold got hs=%0d starts=%0d rdy=%b mvalid=%b want 8 1 0 1",
                     hs2, start_cnt - s0, S_READY, M_VALID);
        end
        wait_outs(base + 16, ok);
        tests_run++;
        if (ok !== 1'b1 || start_cnt - s0 !== 2 || start_cyc <= ocyc[base + 7]) begin
            tests_failed++;
            $display("FAIL bp_second_start got ok=%b starts=%0d start_cyc=%0d want 1 2 after %0d",
                     ok, start_cnt - s0, start_cyc, ocyc[base + 7]);
        end
        tests_run++;
        if (stall_err !== st0) begin
            tests_failed++;
            $display("FAIL bp_stable got %0d stall errors want 0", stall_err - st0);
        end
        for (int j = 0; j < 16; j++) begin
            e0 = (j < 8) ? 64'(12289 + 3 * j) : 64'(36865 + 3 * (j - 8));
            e1 = (j < 8) ? 64'(12288 + j) : 64'(20480 + j - 8);
            g0 = (base + j < oq0.size()) ? oq0[base + j] : 64'hx;
            g1 = (base + j < oq1.size()) ? oq1[base + j] : 64'hx;
            gl = (base + j < ol.size()) ? ol[base + j] : 1'bx;
            tests_run++;
            if (g0 !== e0 || g1 !== e1 || gl !== (j % 8 == 7)) begin
                tests_failed++;
                $display("FAIL bp_out[%0d] got %0d/%0d last=%b want %0d/%0d last=%b",
                         j, g0, g1, gl, e0, e1, (j % 8 == 7));
            end
        end
        rdy_mode = 0;
    endtask

    task automatic test_input_gaps();
        int hs, ex, base;
        logic ok;
        logic [63:0] g0, g1;
        base = oq0.size();
        send_frame(64'h50, 64'h60, 1, 4, hs, ex);
        tests_run++;
        if (hs !== 8 || ex !== 0) begin
            tests_failed++;
            $display("FAIL gaps_handshakes got hs=%0d extra=%0d want 8 0", hs, ex);
        end
        wait_outs(base + 8, ok);
        for (int j = 0; j < 8; j++) begin
            g0 = (base + j < oq0.size()) ? oq0[base + j] : 64'hx;
            g1 = (base + j < oq1.size()) ? oq1[base + j] : 64'hx;
            tests_run++;
            if (ld0[j] !== 64'(80 + j) || g0 !== 64'(241 + 3 * j) || g1 !== 64'(4192 + j)) begin
                tests_failed++;
                $display("FAIL gaps_beat[%0d] got load=%0d out=%0d/%0d want %0d %0d/%0d",
                         j, ld0[j], g0, g1, 80 + j, 241 + 3 * j, 4192 + j);
            end
        end
    endtask

    task automatic test_spurious_done();
        int hs, ex, base, f0;
        logic ok;
        logic [63:0] g0, g1;
        base = oq0.size(); f0 = spur_fires;
        spur_req++;
        step(); step();
        tests_run++;
        if (S_READY !== 1'b1 || M_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL spur_fill got rdy=%b mvalid=%b want 1 0", S_READY, M_VALID);
        end
        spur_load = 1;
        send_frame(64'h70, 64'h80, 0, 0, hs, ex);
        wait_outs(base + 8, ok);
        repeat (60) step();
        spur_load = 0;
        tests_run++;
        if (oq0.size() - base !== 8 || spur_fires - f0 !== 2) begin
            tests_failed++;
            $display("FAIL spur_count got outs=%0d pulses=%0d want 8 2", oq0.size() - base, spur_fires - f0);
        end
        for (int j = 0; j < 8; j++) begin
            g0 = (base + j < oq0.size()) ? oq0[base + j] : 64'hx;
            g1 = (base + j < oq1.size()) ? oq1[base + j] : 64'hx;
            tests_run++;
            if (g0 !== 64'(337 + 3 * j) || g1 !== 64'(4224 + j)) begin
                tests_failed++;
                $display("FAIL spur_out[%0d] got %0d/%0d want %0d/%0d", j, g0, g1, 337 + 3 * j, 4224 + j);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int hs, ex, s0, base, g;
        logic ok;
        logic [63:0] g0, g1;
        s0 = start_cnt; g = 0;
        send_frame(64'h90, 64'hA0, 0, 0, hs, ex);
        while (start_cnt == s0 && g < 100) begin
            step();
            g++;
        end
        repeat (5) step();
        tests_run++;
        if (FFT_D0 !== 64'h94 || FFT_D1 !== 64'hA4) begin
            tests_failed++;
            $display("FAIL rst_beat4 got %h/%h want 94/a4", FFT_D0, FFT_D1);
        end
        RSTn = 0;
        #1;
        tests_run++;
        if ({FFT_D0, FFT_D1} !== 128'b0 || {BUSY, S_READY, FFT_START, M_VALID, M_LAST} !== 5'b0) begin
            tests_failed++;
            $display("FAIL rst_async got lanes=%h ctrl=%b want 0",
                     {FFT_D0, FFT_D1}, {BUSY, S_READY, FFT_START, M_VALID, M_LAST});
        end
        step(); step();
        RSTn = 1;
        step();
        tests_run++;
        if (S_READY !== 1'b1 || M_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_release got rdy=%b mvalid=%b want 1 0", S_READY, M_VALID);
        end
        base = oq0.size();
        send_frame(64'hB0, 64'hC0, 0, 0, hs, ex);
        wait_outs(base + 8, ok);
        repeat (40) step();
        tests_run++;
        if (oq0.size() - base !== 8) begin
            tests_failed++;
            $display("FAIL rst_recover_count got %0d want 8", oq0.size() - base);
        end
        for (int j = 0; j < 8; j++) begin
            g0 = (base + j < oq0.size()) ? oq0[base + j] : 64'hx;
            g1 = (base + j < oq1.size()) ? oq1[base + j] : 64'hx;
            tests_run++;
            if (g0 !== 64'(529 + 3 * j) || g1 !== 64'(4288 + j)) begin
                tests_failed++;
                $display("FAIL rst_recover_out[%0d] got %0d/%0d want %0d/%0d", j, g0, g1, 529 + 3 * j, 4288 + j);
            end
        end
    endtask

`ifdef FFT_HOST_WATCHDOG_EN
    task automatic test_watchdog();
        int hs, ex, s0, base, g;
        s0 = start_cnt; base = oq0.size(); g = 0;
        withhold = 1;
        send_frame(64'hD0, 64'hE0, 0, 0, hs, ex);
        while (start_cnt == s0 && g < 100) begin
            step();
            g++;
        end
        repeat (24) step();
        tests_run++;
        if (ERR !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_early got ERR=%b want 0", ERR);
        end
        step();
        tests_run++;
        if (ERR !== 1'b1 || S_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL wd_fire got ERR=%b rdy=%b want 1 1", ERR, S_READY);
        end
        repeat (20) step();
        tests_run++;
        if (ERR !== 1'b1 || oq0.size() !== base || M_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_sticky got ERR=%b outs=%0d mvalid=%b want 1 0 0", ERR, oq0.size() - base, M_VALID);
        end
        withhold = 0;
    endtask
`else
    task automatic test_err_tied();
        tests_run++;
        if (ERR !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_tied got %b want 0", ERR);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_input_gaps();
        test_spurious_done();
        test_reset_mid_load();
`ifdef FFT_HOST_WATCHDOG_EN
        test_watchdog();
`else
        test_err_tied();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
